pipelined_alu: RTL and testbench
================================

PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal values are powers of two from 4 to 64.
REQ-002 SHALL have derived constant SHW = log2(WIDTH), the shift-amount field width.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request present on op/a/b/c_in.
REQ-006 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port op  input  5  operation code.
REQ-008 SHALL have ports a, b  input  WIDTH  operands.
REQ-009 SHALL have port c_in  input  1  external carry, used by op 0_0111 only.
REQ-010 SHALL have port out_valid  output  1  y/flags hold a completed result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port y  output  WIDTH  registered result.
REQ-013 SHALL have port flags  output  4  registered {V,C,N,Z}, bit 3 down to bit 0.

Function
REQ-014 Ops 0_0000..0_1111 SHALL match the legacy 4-bit ALU map at WIDTH bits: PASSA, INCA, DECA, PASSB, INCB, DECB, ADD, ADC(c_in), NOTA, NOTB, AND, OR, NAND, NOR, XOR, XNOR.
REQ-015 New ops SHALL be: 1_0000 SUB a-b; 1_0001 SBB a-b-cflag; 1_0010 ADCF a+b+cflag; 1_0011 SHL; 1_0100 SHR; 1_0101 SAR; 1_0110 ROL; 1_0111 ROR.
REQ-016 Ops 1_1000..1_1111 SHALL be reserved: result 0, flags Z=1 only, cflag unchanged, latency 1.
REQ-017 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-018 in_ready SHALL be 1 iff state is IDLE and (out_valid is 0 or out_ready is 1), so a held result blocks new requests.
REQ-019 Non-shift ops SHALL have latency 1: out_valid=1 with y/flags on the edge following acceptance.
REQ-020 Shift ops SHALL take amount k = b[SHW-1:0], move one bit per cycle in state SHIFT, and present the result k+1 cycles after acceptance; k=0 SHALL complete at latency 1 with y=a and C=0.
REQ-021 FSM SHALL have states IDLE and SHIFT: IDLE->SHIFT on accepting a shift op with k>0; SHIFT->IDLE when the remaining count reaches 0, loading y/flags/out_valid on that same edge.
REQ-022 out_valid SHALL clear on an edge where out_ready=1 unless a new result loads on that same edge; y and flags SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Z SHALL be (y==0) and N SHALL be y[WIDTH-1] for every op.
REQ-024 C SHALL be the carry-out for INC/ADD/ADC/ADCF, the borrow for DEC/SUB/SBB, and the last bit shifted out for shifts/rotates; C=0 and V=0 for pass/logic ops.
REQ-025 V SHALL be two's-complement overflow for add/sub-class ops and 0 otherwise.
REQ-026 Internal cflag SHALL take the C value of each completed arithmetic or shift op and be left unchanged by pass, logic and reserved ops.
REQ-027 All arithmetic SHALL be computed at WIDTH+1 bits, with y taking the low WIDTH bits.

Reset
REQ-028 While rst=1: state=IDLE, y=0, flags=0, cflag=0, out_valid=0, shift counter=0; an in-progress shift SHALL be discarded with no partial result emitted.
REQ-029 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after release.

Structure
REQ-030 Package alu_pkg SHALL hold the op-code enum, the FSM state enum and the flag bit-index constants.
REQ-031 Single-cycle datapath SHALL be sub-module alu_core (combinational: op, a, b, carry-in -> result, C, V); the FSM, shifter and registers SHALL reside in pipelined_alu.

Verification (WIDTH=8)
REQ-032 ADD a=FF b=01 -> y=00, flags Z=1 C=1 N=0 V=0, out_valid 1 cycle after accept.
REQ-033 ADD a=7F b=01 -> y=80, N=1 V=1 C=0 Z=0.
REQ-034 SUB a=00 b=01 -> y=FF, C=1 N=1; then SBB a=05 b=02 -> y=02, C=0.
REQ-035 SHL a=81 b=03 -> in_ready=0 for 3 cycles, out_valid 4 cycles after accept, y=08, C=0.
REQ-036 ADD completes with out_ready=0 for 5 cycles -> y/flags stable, in_ready=0; out_ready=1 -> out_valid clears next edge.
REQ-037 rst asserted during SHIFT (ROR a=01 b=07) -> out_valid=0 and y=00 immediately; in_ready=1 the cycle after release; no result emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU: operation codes, the FSM state
// encoding, flag bit positions and a small op-classification helper.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  // Operation codes. 0_xxxx is the legacy 4-bit ALU map; 1_1000..1_1111 are
  // reserved and intentionally absent from the enum.
  typedef enum logic [4:0] {
    OP_PASSA = 5'b0_0000,
    OP_INCA  = 5'b0_0001,
    OP_DECA  = 5'b0_0010,
    OP_PASSB = 5'b0_0011,
    OP_INCB  = 5'b0_0100,
    OP_DECB  = 5'b0_0101,
    OP_ADD   = 5'b0_0110,
    OP_ADC   = 5'b0_0111,
    OP_NOTA  = 5'b0_1000,
    OP_NOTB  = 5'b0_1001,
    OP_AND   = 5'b0_1010,
    OP_OR    = 5'b0_1011,
    OP_NAND  = 5'b0_1100,
    OP_NOR   = 5'b0_1101,
    OP_XOR   = 5'b0_1110,
    OP_XNOR  = 5'b0_1111,
    OP_SUB   = 5'b1_0000,
    OP_SBB   = 5'b1_0001,
    OP_ADCF  = 5'b1_0010,
    OP_SHL   = 5'b1_0011,
    OP_SHR   = 5'b1_0100,
    OP_SAR   = 5'b1_0101,
    OP_ROL   = 5'b1_0110,
    OP_ROR   = 5'b1_0111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  // Bit positions inside the {V,C,N,Z} flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // True for the five multi-cycle shift/rotate ops.
  function automatic logic is_shift_op(input logic [4:0] op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational single-cycle datapath. All add/sub-class ops share one
// WIDTH+1-bit adder/subtractor whose top bit is the carry (add) or borrow (sub).
// Shift ops pass operand a through unchanged: that is the k=0 result, and the
// multi-cycle shifter in the top handles every other amount.
// Ports:
//   i_op     operation code
//   i_a/i_b  operands
//   i_c_in   external carry (ADC only)
//   i_cflag  stored carry flag (SBB/ADCF)
//   o_y      result
//   o_c/o_v  carry/borrow and signed overflow
//   o_upd_c  op is arithmetic or shift, so the stored carry flag takes o_c
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
  input  logic             i_cflag,
  output logic [WIDTH-1:0] o_y,
  output logic             o_c,
  output logic             o_v,
  output logic             o_upd_c
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_z;
  logic [WIDTH-1:0] w_logic;
  logic             w_ci;
  logic             w_sub;
  logic             w_arith;
  logic             w_shift;
  logic [WIDTH:0]   w_ext;
  logic             w_ovf;

  // Decode: pick adder operands/direction, or produce the pass/logic result
  always_comb begin
    w_x     = i_a;
    w_z     = i_b;
    w_ci    = 1'b0;
    w_sub   = 1'b0;
    w_arith = 1'b0;
    w_shift = 1'b0;
    w_logic = {WIDTH{1'b0}};
    case (i_op)
      OP_PASSA: w_logic = i_a;
      OP_INCA:  begin w_z = ONE; w_arith = 1'b1; end
      OP_DECA:  begin w_z = ONE; w_sub = 1'b1; w_arith = 1'b1; end
      OP_PASSB: w_logic = i_b;
      OP_INCB:  begin w_x = i_b; w_z = ONE; w_arith = 1'b1; end
      OP_DECB:  begin w_x = i_b; w_z = ONE; w_sub = 1'b1; w_arith = 1'b1; end
      OP_ADD:   w_arith = 1'b1;
      OP_ADC:   begin w_ci = i_c_in; w_arith = 1'b1; end
      OP_NOTA:  w_logic = ~i_a;
      OP_NOTB:  w_logic = ~i_b;
      OP_AND:   w_logic = i_a & i_b;
      OP_OR:    w_logic = i_a | i_b;
      OP_NAND:  w_logic = ~(i_a & i_b);
      OP_NOR:   w_logic = ~(i_a | i_b);
      OP_XOR:   w_logic = i_a ^ i_b;
      OP_XNOR:  w_logic = ~(i_a ^ i_b);
      OP_SUB:   begin w_sub = 1'b1; w_arith = 1'b1; end
      OP_SBB:   begin w_ci = i_cflag; w_sub = 1'b1; w_arith = 1'b1; end
      OP_ADCF:  begin w_ci = i_cflag; w_arith = 1'b1; end
      OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
        w_logic = i_a;
        w_shift = 1'b1;
      end
      default:  w_logic = {WIDTH{1'b0}};  // reserved ops yield zero
    endcase
  end

  // Shared WIDTH+1-bit adder/subtractor; subtraction overflows when the
  // operand signs differ and the result sign departs from the minuend
  always_comb begin
    if (w_sub) begin
      w_ext = {1'b0, w_x} - {1'b0, w_z} - {{WIDTH{1'b0}}, w_ci};
      w_ovf = (w_x[WIDTH-1] != w_z[WIDTH-1]) && (w_ext[WIDTH-1] != w_x[WIDTH-1]);
    end else begin
      w_ext = {1'b0, w_x} + {1'b0, w_z} + {{WIDTH{1'b0}}, w_ci};
      w_ovf = (w_x[WIDTH-1] == w_z[WIDTH-1]) && (w_ext[WIDTH-1] != w_x[WIDTH-1]);
    end
  end

  // Result and flag select
  always_comb begin
    if (w_arith) begin
      o_y = w_ext[WIDTH-1:0];
      o_c = w_ext[WIDTH];
      o_v = w_ovf;
    end else begin
      o_y = w_logic;
      o_c = 1'b0;
      o_v = 1'b0;
    end
  end

  assign o_upd_c = w_arith | w_shift;

endmodule

// File: rtl/pipelined_alu.sv
// -----------------------------------------------------------------------------
// pipelined_alu
// Valid/ready wrapped ALU. Single-cycle ops complete on the accepting edge;
// shift/rotate ops move one bit per cycle in the SHIFT state and complete on
// the k-th edge after acceptance. A held (unconsumed) result blocks new
// requests.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    request handshake for op, a, b, c_in
//   op                   5-bit operation code
//   a, b                 operands (b[SHW-1:0] is the shift amount)
//   c_in                 external carry for ADC
//   out_valid/out_ready  result handshake
//   y                    registered result
//   flags                registered {V,C,N,Z}
// -----------------------------------------------------------------------------
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  alu_state_e       r_state;
  logic [4:0]       r_op;
  logic [WIDTH-1:0] r_sh;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_y;
  logic [3:0]       r_flags;
  logic             r_cflag;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_core_y;
  logic             w_core_c;
  logic             w_core_v;
  logic             w_core_upd;
  logic [SHW-1:0]   w_k;
  logic             w_accept;
  logic             w_shift_start;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_sh_c;

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = res[WIDTH-1];
    f[FLAG_Z] = (res == {WIDTH{1'b0}});
    return f;
  endfunction

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .i_c_in  (c_in),
    .i_cflag (r_cflag),
    .o_y     (w_core_y),
    .o_c     (w_core_c),
    .o_v     (w_core_v),
    .o_upd_c (w_core_upd)
  );

  assign w_k           = b[SHW-1:0];
  assign in_ready      = ~rst & (r_state == ST_IDLE) & (~r_out_valid | out_ready);
  assign w_accept      = in_valid & in_ready;
  // k=0 shifts complete in one cycle through the core's pass-through path
  assign w_shift_start = is_shift_op(op) && (w_k != {SHW{1'b0}});

  // One-bit shift/rotate step; carry is the bit that leaves the register
  always_comb begin
    w_sh_next = r_sh;
    w_sh_c    = 1'b0;
    case (r_op)
      OP_SHL:  begin w_sh_next = {r_sh[WIDTH-2:0], 1'b0};         w_sh_c = r_sh[WIDTH-1]; end
      OP_SHR:  begin w_sh_next = {1'b0, r_sh[WIDTH-1:1]};         w_sh_c = r_sh[0];       end
      OP_SAR:  begin w_sh_next = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]}; w_sh_c = r_sh[0];      end
      OP_ROL:  begin w_sh_next = {r_sh[WIDTH-2:0], r_sh[WIDTH-1]}; w_sh_c = r_sh[WIDTH-1]; end
      OP_ROR:  begin w_sh_next = {r_sh[0], r_sh[WIDTH-1:1]};      w_sh_c = r_sh[0];       end
      default: begin w_sh_next = r_sh;                           w_sh_c = 1'b0;          end
    endcase
  end

  // Control FSM, shifter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= 5'b0_0000;
      r_sh        <= {WIDTH{1'b0}};
      r_cnt       <= {SHW{1'b0}};
      r_y         <= {WIDTH{1'b0}};
      r_flags     <= 4'b0000;
      r_cflag     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // Consumed result drops; a load below on the same edge overrides this
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_shift_start) begin
              r_state <= ST_SHIFT;
              r_op    <= op;
              r_sh    <= a;
              r_cnt   <= w_k;
            end else begin
              r_y         <= w_core_y;
              r_flags     <= pack_flags(w_core_y, w_core_c, w_core_v);
              r_out_valid <= 1'b1;
              if (w_core_upd) begin
                r_cflag <= w_core_c;
              end
            end
          end
        end
        ST_SHIFT: begin
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt - CNT_ONE;
          // Last step: the count reaches zero and the result loads now
          if (r_cnt == CNT_ONE) begin
            r_state     <= ST_IDLE;
            r_y         <= w_sh_next;
            r_flags     <= pack_flags(w_sh_next, w_sh_c, 1'b0);
            r_cflag     <= w_sh_c;
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign flags     = r_flags;

endmodule

// File: tb/tb_pipelined_alu.sv
// -----------------------------------------------------------------------------
// tb_pipelined_alu
// Scoreboard bench for pipelined_alu at WIDTH=8. Each accepted request pushes
// its expected {y, flags, latency} computed by a behavioural model; a monitor
// pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_pipelined_alu;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [3:0] flags;

  pipelined_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags)
  );

  typedef struct {
    logic [7:0] y;
    logic [3:0] f;
    int         lat;
    bit         chk_lat;
    int         acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic m_cflag = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: whole-value shifts and integer-range arithmetic
  task automatic model(input logic [4:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic ci, output logic [7:0] ey, output logic [3:0] ef,
                       output int elat);
    logic [7:0] r, x, z;
    logic c, v, cin;
    bit ar, sb, upd;
    int k, s, sv;
    r = 8'h00; x = aa; z = bb; c = 1'b0; v = 1'b0; cin = 1'b0;
    ar = 0; sb = 0; upd = 0; k = int'(bb[2:0]); elat = 1; s = 0; sv = 0;
    case (o)
      OP_PASSA: r = aa;
      OP_INCA:  begin ar = 1; z = 8'd1; end
      OP_DECA:  begin ar = 1; sb = 1; z = 8'd1; end
      OP_PASSB: r = bb;
      OP_INCB:  begin ar = 1; x = bb; z = 8'd1; end
      OP_DECB:  begin ar = 1; sb = 1; x = bb; z = 8'd1; end
      OP_ADD:   ar = 1;
      OP_ADC:   begin ar = 1; cin = ci; end
      OP_NOTA:  r = ~aa;
      OP_NOTB:  r = ~bb;
      OP_AND:   r = aa & bb;
      OP_OR:    r = aa | bb;
      OP_NAND:  r = ~(aa & bb);
      OP_NOR:   r = ~(aa | bb);
      OP_XOR:   r = aa ^ bb;
      OP_XNOR:  r = ~(aa ^ bb);
      OP_SUB:   begin ar = 1; sb = 1; end
      OP_SBB:   begin ar = 1; sb = 1; cin = m_cflag; end
      OP_ADCF:  begin ar = 1; cin = m_cflag; end
      OP_SHL:   begin r = aa << k; c = (k != 0) ? aa[8-k] : 1'b0; end
      OP_SHR:   begin r = aa >> k; c = (k != 0) ? aa[k-1] : 1'b0; end
      OP_SAR:   begin r = $signed(aa) >>> k; c = (k != 0) ? aa[k-1] : 1'b0; end
      OP_ROL:   begin r = (aa << k) | (aa >> (8 - k)); c = (k != 0) ? r[0] : 1'b0; end
      OP_ROR:   begin r = (aa >> k) | (aa << (8 - k)); c = (k != 0) ? r[7] : 1'b0; end
      default:  r = 8'h00;
    endcase
    if (o >= OP_SHL && o <= OP_ROR) begin
      upd  = 1;
      elat = k + 1;
    end
    if (ar) begin
      upd = 1;
      if (sb) begin
        s  = int'(x) - int'(z) - int'(cin);
        sv = int'($signed(x)) - int'($signed(z)) - int'(cin);
        c  = (s < 0);
      end else begin
        s  = int'(x) + int'(z) + int'(cin);
        sv = int'($signed(x)) + int'($signed(z)) + int'(cin);
        c  = (s > 255);
      end
      r = s[7:0];
      v = (sv > 127) || (sv < -128);
    end
    if (upd) m_cflag = c;
    ey = r;
    ef = {v, c, r[7], (r == 8'h00)};
  endtask

  task automatic send(input logic [4:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic ci, input bit chk_lat);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    op = o; a = aa; b = bb; c_in = ci; in_valid = 1'b1;
    model(o, aa, bb, ci, e.y, e.f, e.lat);
    e.chk_lat = chk_lat;
    e.acc     = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain", sb_q.size(), 32'd0);
  endtask

  // Output monitor: every handshake must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("y", {24'd0, y}, {24'd0, mon_e.y});
        check_eq("flags", {28'd0, flags}, {28'd0, mon_e.f});
        if (mon_e.chk_lat) check_eq("latency", cyc - mon_e.acc + 1, mon_e.lat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 5'd0; a = 8'h00; b = 8'h00; c_in = 1'b0;
    out_ready = 1'b1;
    #1 check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_y", {24'd0, y}, 32'd0);
    check_eq("rst_flags", {28'd0, flags}, 32'd0);
    rst = 1'b0;
    m_cflag = 1'b0;
    #1 check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed arithmetic corners
    send(OP_ADD, 8'hFF, 8'h01, 1'b0, 1);
    send(OP_ADD, 8'h7F, 8'h01, 1'b0, 1);
    send(OP_SUB, 8'h00, 8'h01, 1'b0, 1);
    send(OP_SBB, 8'h05, 8'h02, 1'b0, 1);
    send(OP_ADC, 8'hF0, 8'h0F, 1'b1, 1);
    send(OP_INCA, 8'hFF, 8'h00, 1'b0, 1);
    send(OP_DECB, 8'h00, 8'h80, 1'b0, 1);
    send(OP_ADCF, 8'h10, 8'h20, 1'b0, 1);
    send(OP_SUB, 8'h80, 8'h01, 1'b0, 1);
    send(OP_XNOR, 8'h5A, 8'h5A, 1'b0, 1);
    send(OP_SBB, 8'h00, 8'h7F, 1'b0, 1);
    drain();

    // SHL a=81 k=3: busy for three cycles, result on the fourth
    send(OP_SHL, 8'h81, 8'h03, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("shl_busy_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    check_eq("shl_done_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("shl_done_valid", {31'd0, out_valid}, 32'd1);

    // Shift/rotate variety including k=0 and reserved ops
    send(OP_SAR, 8'h80, 8'h02, 1'b0, 1);
    send(OP_SHR, 8'h03, 8'h01, 1'b0, 1);
    send(OP_ROL, 8'h81, 8'h01, 1'b0, 1);
    send(OP_ROR, 8'h01, 8'h07, 1'b0, 1);
    send(OP_ROR, 8'hA5, 8'h00, 1'b0, 1);
    send(5'b1_1010, 8'h12, 8'h34, 1'b0, 1);
    send(OP_ADCF, 8'h00, 8'h00, 1'b0, 1);
    drain();

    // Random mix
    for (int i = 0; i < 40; i++) begin
      send(5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom), 1'($urandom), 1);
    end
    drain();

    // Back-pressure: held result stays stable and blocks new requests
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(OP_ADD, 8'h12, 8'h34, 1'b0, 0);
    @(negedge clk);
    check_eq("stall_valid_lat1", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_y", {24'd0, y}, 32'h46);
      check_eq("stall_flags", {28'd0, flags}, 32'd0);
      check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("stall_valid_clear", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset during SHIFT: leave cflag set first, then discard a ROR
    send(OP_SUB, 8'h00, 8'h01, 1'b0, 1);
    drain();
    @(negedge clk);
    op = OP_ROR; a = 8'h01; b = 8'h07; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("shift_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_mid_y", {24'd0, y}, 32'd0);
    check_eq("rst_mid_flags", {28'd0, flags}, 32'd0);
    check_eq("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    m_cflag = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check_eq("rel2_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) @(negedge clk);
    check_eq("no_partial_result", sb_q.size(), 32'd0);
    // cflag must have been cleared by reset
    send(OP_ADCF, 8'h10, 8'h20, 1'b0, 1);
    drain();
    @(negedge clk);
    check_eq("final_idle", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
